// File: rtl/slc3_mem_arbiter.sv
// Arbitrates the single SLC-3 SRAM between the CPU MAR/MDR port and the program loader.
// One access in flight: IDLE -> ISSUE -> (WAIT x RD_LAT) -> DONE, with a one-cycle ready pulse.
module slc3_mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int RD_LAT      = 2,
    parameter int LOADER_PRIO = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ready,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state, state_nxt;
    logic              any_req, winner;
    logic              lat_we, owner_q, rr_ptr;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata, cpu_rd_q, ld_rd_q;
    logic [3:0]        cnt;

    assign any_req = cpu_req | ld_req;
    // rr_ptr = 1 means the loader is favoured on the next tie
    assign winner  = ld_req & (~cpu_req | (LOADER_PRIO != 0) | rr_ptr);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = lat_we ? DONE : WAIT;
            WAIT:    if (cnt == 4'd1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            owner_q   <= 1'b0;
            rr_ptr    <= 1'b0;
            cnt       <= 4'd0;
            cpu_rd_q  <= '0;
            ld_rd_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        lat_we    <= winner ? ld_we    : cpu_we;
                        lat_addr  <= winner ? ld_addr  : cpu_addr;
                        lat_wdata <= winner ? ld_wdata : cpu_wdata;
                        owner_q   <= winner;
                        rr_ptr    <= ~winner;
                    end
                end
                ISSUE: cnt <= 4'(RD_LAT);
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    // last WAIT cycle is exactly RD_LAT cycles after the mem_ce cycle
                    if (cnt == 4'd1) begin
                        if (owner_q) ld_rd_q  <= mem_rdata;
                        else         cpu_rd_q <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_ce    = (state == ISSUE);
    assign mem_we    = mem_ce & lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign busy      = (state != IDLE);
    assign owner     = owner_q;
    assign cpu_ready = (state == DONE) & ~owner_q;
    assign ld_ready  = (state == DONE) & owner_q;
    assign cpu_rdata = cpu_rd_q;
    assign ld_rdata  = ld_rd_q;
endmodule
